exe_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID stage register and consumes that register's outputs.
- Single-cycle ops: ALU operations, branch resolution, memory address generation.
- Multi-cycle op: a signed iterative multiplier. While it runs, the block asserts stall upstream and drives bubbles downstream.
- Outputs feed the EXE/MEM stage register and the IF-stage PC mux.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/exe_mul_iter.sv | 108 ++++++++++
 rtl/exe_stage.sv | 146 ++++++++++++++
 tb/tb_exe_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: execute-stage command codes, branch kinds
// and the iterative multiplier FSM encoding.
// Optional feature macro: EXE_MULH_EN (adds EXE_MULH as a multi-cycle command).
package mips_pkg;

  typedef enum logic [3:0] {
    EXE_ADD  = 4'h0,
    EXE_SUB  = 4'h1,
    EXE_AND  = 4'h2,
    EXE_OR   = 4'h3,
    EXE_NOR  = 4'h4,
    EXE_XOR  = 4'h5,
    EXE_SLL  = 4'h6,
    EXE_SRA  = 4'h7,
    EXE_SRL  = 4'h8,
    EXE_MUL  = 4'h9,
    EXE_MULH = 4'hA
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  typedef enum logic [1:0] {
    MulIdle = 2'd0,
    MulBusy = 2'd1,
    MulDone = 2'd2
  } mul_state_e;

  // Wide enough for N-1 with one bit retired per cycle (31).
  localparam int unsigned MulCntW = 5;

  // True for commands that go through the iterative multiplier.
  function automatic logic is_mul_cmd(logic [3:0] cmd);
`ifdef EXE_MULH_EN
    return (cmd == EXE_MUL) || (cmd == EXE_MULH);
`else
    return (cmd == EXE_MUL);
`endif
  endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// Signed iterative multiplier: IDLE -> BUSY (N = 32/MUL_BITS_PER_CYCLE cycles) -> DONE.
// Operands are multiplied as unsigned, then the high word is corrected for
// two's complement on the last BUSY cycle.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             multiply request, only acted on in IDLE
//   a_i, b_i            operands, captured on start
//   busy_o              high in BUSY
//   done_o              high in DONE, product_o is valid
//   product_o           signed 64-bit product
module exe_mul_iter
  import mips_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 2  // 1, 2 or 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  localparam int unsigned N = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [MulCntW-1:0] CntLoad = MulCntW'(N - 1);

  mul_state_e         state_q, state_d;
  logic [MulCntW-1:0] cnt_q, cnt_d;
  logic [63:0]        acc_q, acc_d;
  logic [63:0]        mcand_q, mcand_d;
  logic [31:0]        mplier_q, mplier_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [63:0]        acc_step;
  logic [31:0]        hi_corr;

  // One iteration: add the partial products for the low multiplier bits.
  always_comb begin
    acc_step = acc_q;
    for (int i = 0; i < int'(MUL_BITS_PER_CYCLE); i++) begin
      if (mplier_q[5'(i)]) acc_step = acc_step + (mcand_q << i);
    end
    // Signed = unsigned - 2^32 * (a<0 ? b : 0) - 2^32 * (b<0 ? a : 0), mod 2^64.
    hi_corr = (a_q[31] ? b_q : 32'h0) + (b_q[31] ? a_q : 32'h0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    a_d      = a_q;
    b_d      = b_q;
    case (state_q)
      MulIdle: begin
        if (start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          mcand_d  = {32'h0, a_i};
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = CntLoad;
          state_d  = MulBusy;
        end
      end
      MulBusy: begin
        mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
        mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
        if (cnt_q == '0) begin
          acc_d   = acc_step - {hi_corr, 32'h0};
          state_d = MulDone;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - MulCntW'(1);
        end
      end
      MulDone: state_d = MulIdle;
      default: state_d = MulIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MulIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign busy_o    = (state_q == MulBusy);
  assign done_o    = (state_q == MulDone);
  assign product_o = acc_q;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: combinational ALU, branch unit and address generation,
// plus a multi-cycle signed multiply (exe_mul_iter) that stalls upstream and
// sends bubbles downstream while it runs.
// Optional feature macro: EXE_MULH_EN (EXE_Cmd 4'hA returns product[63:32]).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   EXE_Cmd, data1, data2,
//   Immediate, Is_Imm             operation and (forwarded) operands
//   BR_Type, PC                   branch kind and PC+4
//   dest, WB_En, MEM_R_En,
//   MEM_W_En                      destination and control from ID
//   ALU_Res, ST_Val, dest_out,
//   *_out enables                 to the EXE/MEM register
//   Br_Taken, Br_Addr             PC redirect
//   mul_stall                     hold PC and IF/ID, bubble ID
module exe_stage
  import mips_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 2  // 1, 2 or 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_Cmd,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] Immediate,
  input  logic        Is_Imm,
  input  logic [1:0]  BR_Type,
  input  logic [31:0] PC,
  input  logic [4:0]  dest,
  input  logic        WB_En,
  input  logic        MEM_R_En,
  input  logic        MEM_W_En,
  output logic [31:0] ALU_Res,
  output logic [31:0] ST_Val,
  output logic [4:0]  dest_out,
  output logic        WB_En_out,
  output logic        MEM_R_En_out,
  output logic        MEM_W_En_out,
  output logic        Br_Taken,
  output logic [31:0] Br_Addr,
  output logic        mul_stall
);

  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        br_cond;
  logic        mul_cmd, mul_busy, mul_done, mul_idle, mul_start;
  logic [63:0] mul_product;
  logic [4:0]  dest_q, dest_d;
  logic        wb_q, wb_d;
  logic        hi_q, hi_d;

  assign op_b      = Is_Imm ? Immediate : data2;
  assign mul_cmd   = is_mul_cmd(EXE_Cmd);
  assign mul_idle  = !mul_busy && !mul_done;
  assign mul_start = mul_cmd && mul_idle;

  exe_mul_iter #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk_i    (clk),
    .rst_ni   (rst),
    .start_i  (mul_cmd),
    .a_i      (data1),
    .b_i      (op_b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // Writeback fields of the in-flight multiply, captured with the operands.
  assign dest_d = mul_start ? dest : dest_q;
  assign wb_d   = mul_start ? WB_En : wb_q;
`ifdef EXE_MULH_EN
  assign hi_d   = mul_start ? (EXE_Cmd == EXE_MULH) : hi_q;
`else
  assign hi_d   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_q <= '0;
      wb_q   <= 1'b0;
      hi_q   <= 1'b0;
    end else begin
      dest_q <= dest_d;
      wb_q   <= wb_d;
      hi_q   <= hi_d;
    end
  end

  always_comb begin
    alu_res = '0;
    case (EXE_Cmd)
      EXE_ADD: alu_res = data1 + op_b;
      EXE_SUB: alu_res = data1 - op_b;
      EXE_AND: alu_res = data1 & op_b;
      EXE_OR:  alu_res = data1 | op_b;
      EXE_NOR: alu_res = ~(data1 | op_b);
      EXE_XOR: alu_res = data1 ^ op_b;
      EXE_SLL: alu_res = data1 << op_b[4:0];
      EXE_SRA: alu_res = $signed(data1) >>> op_b[4:0];
      EXE_SRL: alu_res = data1 >> op_b[4:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (BR_Type)
      BR_BEZ:  br_cond = (data1 == 32'h0);
      BR_BNE:  br_cond = (data1 != data2);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign ST_Val  = data2;
  assign Br_Addr = PC + (Immediate << 2);

  always_comb begin
    ALU_Res      = alu_res;
    dest_out     = dest;
    WB_En_out    = WB_En;
    MEM_R_En_out = MEM_R_En;
    MEM_W_En_out = MEM_W_En;
    // rst gating keeps stall/redirect quiet while the system is in reset.
    Br_Taken     = rst && mul_idle && br_cond;
    mul_stall    = rst && (mul_start || mul_busy);
    if (mul_done) begin
      ALU_Res      = hi_q ? mul_product[63:32] : mul_product[31:0];
      dest_out     = dest_q;
      WB_En_out    = wb_q;
      MEM_R_En_out = 1'b0;
      MEM_W_En_out = 1'b0;
    end else if (mul_stall) begin
      ALU_Res      = '0;
      dest_out     = '0;
      WB_En_out    = 1'b0;
      MEM_R_En_out = 1'b0;
      MEM_W_En_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed pins from hand-computed values plus a random
// run checked every cycle against a behavioural model of the stage.
module tb_exe_stage;

  localparam int unsigned K = 2;
  localparam int unsigned N = 32 / K;
`ifdef EXE_MULH_EN
  localparam bit MulhOn = 1'b1;
`else
  localparam bit MulhOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  EXE_Cmd = '0;
  logic [31:0] data1 = '0, data2 = '0, Immediate = '0, PC = '0;
  logic        Is_Imm = 1'b0;
  logic [1:0]  BR_Type = '0;
  logic [4:0]  dest = '0;
  logic        WB_En = 1'b0, MEM_R_En = 1'b0, MEM_W_En = 1'b0;
  logic [31:0] ALU_Res, ST_Val, Br_Addr;
  logic [4:0]  dest_out;
  logic        WB_En_out, MEM_R_En_out, MEM_W_En_out, Br_Taken, mul_stall;

  int total = 0;
  int bad   = 0;

  // Expectations for the current cycle.
  bit          chk_en = 1'b0;
  logic [31:0] e_alu, e_st, e_bra;
  logic [4:0]  e_dest;
  bit          e_dest_chk;
  logic        e_wb, e_mr, e_mw, e_brt, e_stall;

  // Model state: stall cycles still owed, pending result.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic [4:0]  m_dest = '0;
  logic        m_wb   = 1'b0;

  always #5 clk = ~clk;

  exe_stage #(
    .MUL_BITS_PER_CYCLE(K)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .EXE_Cmd     (EXE_Cmd),
    .data1       (data1),
    .data2       (data2),
    .Immediate   (Immediate),
    .Is_Imm      (Is_Imm),
    .BR_Type     (BR_Type),
    .PC          (PC),
    .dest        (dest),
    .WB_En       (WB_En),
    .MEM_R_En    (MEM_R_En),
    .MEM_W_En    (MEM_W_En),
    .ALU_Res     (ALU_Res),
    .ST_Val      (ST_Val),
    .dest_out    (dest_out),
    .WB_En_out   (WB_En_out),
    .MEM_R_En_out(MEM_R_En_out),
    .MEM_W_En_out(MEM_W_En_out),
    .Br_Taken    (Br_Taken),
    .Br_Addr     (Br_Addr),
    .mul_stall   (mul_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ~(a | b);
      4'd5:    return a ^ b;
      4'd6:    return a << b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_is_mul(logic [3:0] c);
    return (c == 4'd9) || (MulhOn && c == 4'd10);
  endfunction

  // Expected outputs for the inputs just applied, then advance the model one cycle.
  task automatic model_eval();
    logic [31:0] ob;
    logic [63:0] ax, bx, p;
    bit          nbrt;
    ob    = Is_Imm ? Immediate : data2;
    nbrt  = (BR_Type == 2'd1 && data1 == 0) || (BR_Type == 2'd2 && data1 != data2) ||
            (BR_Type == 2'd3);
    e_st  = data2;
    e_bra = PC + (Immediate << 2);
    e_dest_chk = 1'b1;
    e_alu = ref_alu(EXE_Cmd, data1, ob);
    e_dest = dest; e_wb = WB_En; e_mr = MEM_R_En; e_mw = MEM_W_En;
    e_stall = 1'b0; e_brt = nbrt;
    if (!rst) begin
      e_brt  = 1'b0;
      m_left = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      e_alu = m_res; e_dest = m_dest; e_wb = m_wb; e_mr = 1'b0; e_mw = 1'b0; e_brt = 1'b0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      e_alu = 0; e_wb = 0; e_mr = 0; e_mw = 0; e_dest_chk = 1'b0;
      e_stall = 1'b1; e_brt = 1'b0;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (ref_is_mul(EXE_Cmd)) begin
      e_alu = 0; e_wb = 0; e_mr = 0; e_mw = 0; e_dest_chk = 1'b0;
      e_stall = 1'b1;
      ax = {{32{data1[31]}}, data1};
      bx = {{32{ob[31]}}, ob};
      p  = ax * bx;
      m_res  = (EXE_Cmd == 4'd10) ? p[63:32] : p[31:0];
      m_dest = dest;
      m_wb   = WB_En;
      m_left = N;
    end
  endtask

  task automatic apply(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic ii, input logic [1:0] br,
                       input logic [31:0] pc, input logic [4:0] d, input logic wb,
                       input logic mr, input logic mw, input logic r);
    @(posedge clk);
    #1;
    EXE_Cmd = c; data1 = a; data2 = b; Immediate = imm; Is_Imm = ii; BR_Type = br;
    PC = pc; dest = d; WB_En = wb; MEM_R_En = mr; MEM_W_En = mw; rst = r;
    model_eval();
    chk_en = 1'b1;
  endtask

  task automatic bubble(input logic r);
    apply(4'd0, 0, 0, 0, 1'b0, 2'd0, 0, 5'd0, 1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_res", ALU_Res, e_alu);
      chk("st_val", ST_Val, e_st);
      chk("br_addr", Br_Addr, e_bra);
      chk("br_taken", 32'(Br_Taken), 32'(e_brt));
      chk("mul_stall", 32'(mul_stall), 32'(e_stall));
      chk("wb_en", 32'(WB_En_out), 32'(e_wb));
      chk("mem_r_en", 32'(MEM_R_En_out), 32'(e_mr));
      chk("mem_w_en", 32'(MEM_W_En_out), 32'(e_mw));
      if (e_dest_chk) chk("dest", 32'(dest_out), 32'(e_dest));
    end
  end

  initial begin
    logic [3:0] c;
    logic       r;
    // Reset with a MUL and a JMP on the inputs: neither stall nor redirect.
    apply(4'd9, 32'h3, 32'h4, 0, 1'b0, 2'd3, 32'h40, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("pin_rst_stall", 32'(mul_stall), 32'h0);
    chk("pin_rst_brt", 32'(Br_Taken), 32'h0);

    apply(4'd0, 32'h7FFF_FFFF, 32'h1, 0, 1'b0, 2'd0, 0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_add_wrap", ALU_Res, 32'h8000_0000);
    apply(4'd7, 32'h8000_0000, 32'h0, 32'h4, 1'b1, 2'd0, 0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_sra", ALU_Res, 32'hF800_0000);
    apply(4'd4, 32'h0, 32'h0, 0, 1'b0, 2'd0, 0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_nor", ALU_Res, 32'hFFFF_FFFF);
    apply(4'd0, 32'h5, 32'h6, 32'h3, 1'b0, 2'd2, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_bne_taken", 32'(Br_Taken), 32'h1);
    chk("pin_bne_addr", Br_Addr, 32'h10C);
    apply(4'd0, 32'h1, 32'h0, 32'h3, 1'b0, 2'd1, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_bez_not", 32'(Br_Taken), 32'h0);

    // -3 * 7 into r9.
    apply(4'd9, 32'hFFFF_FFFD, 32'h7, 0, 1'b0, 2'd0, 0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_mul_stall_t", 32'(mul_stall), 32'h1);
    chk("pin_mul_wb_t", 32'(WB_En_out), 32'h0);
    for (int i = 0; i < int'(N); i++) begin
      bubble(1'b1);
      settle();
      chk("pin_mul_stall_busy", 32'(mul_stall), 32'h1);
      chk("pin_mul_wb_busy", 32'(WB_En_out), 32'h0);
    end
    bubble(1'b1);
    settle();
    chk("pin_mul_res", ALU_Res, 32'hFFFF_FFEB);
    chk("pin_mul_dest", 32'(dest_out), 32'd9);
    chk("pin_mul_wb", 32'(WB_En_out), 32'h1);
    chk("pin_mul_stall_done", 32'(mul_stall), 32'h0);
    apply(4'd0, 32'h2, 32'h3, 0, 1'b0, 2'd0, 0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_b2b_add", ALU_Res, 32'h5);
    bubble(1'b1);
    settle();
    chk("pin_no_dup_wb", 32'(WB_En_out), 32'h0);

    // Reset at t+5 of a multiply.
    apply(4'd9, 32'h3, 32'h4, 0, 1'b0, 2'd0, 0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) bubble(1'b1);
    bubble(1'b0);
    settle();
    chk("pin_rst_mid_stall", 32'(mul_stall), 32'h0);
    apply(4'd0, 32'h1, 32'h1, 0, 1'b0, 2'd0, 0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("pin_after_rst_add", ALU_Res, 32'h2);
    chk("pin_after_rst_stall", 32'(mul_stall), 32'h0);

    // Code 4'hA: MULH when enabled, undefined otherwise.
    apply(4'hA, 32'h8000_0000, 32'h2, 0, 1'b0, 2'd0, 0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
`ifdef EXE_MULH_EN
    for (int i = 0; i < int'(N); i++) bubble(1'b1);
    bubble(1'b1);
    settle();
    chk("pin_mulh", ALU_Res, 32'hFFFF_FFFF);
`else
    chk("pin_cmd_a_res", ALU_Res, 32'h0);
    chk("pin_cmd_a_stall", 32'(mul_stall), 32'h0);
`endif

    // Zero operand via the immediate path, with writeback disabled.
    apply(4'd9, 32'h1234, 32'h55, 32'h0, 1'b1, 2'd0, 0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < int'(N) + 1; i++) bubble(1'b1);

    // Random run; inputs during BUSY/DONE are garbage and must be ignored.
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom_range(0, 7) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 199) != 0);
      apply(c, rnd32(), rnd32(), rnd32(), 1'($urandom), 2'($urandom), $urandom,
            5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), r);
    end
    settle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
